// File: rtl/multicycle_control.sv
// multicycle_control
//   Main controller of a multicycle MIPS-style datapath. It is a Moore FSM
//   that steps each instruction through FETCH/DECODE and then through the
//   opcode-specific execute, memory and writeback states.
//
//   Ports:
//     clk       system clock; the state register updates on its rising edge
//     rst       asynchronous, active-high reset; forces FETCH
//     Op        opcode field, instruction bits [31:26]
//     Zero      ALU zero flag; gates PCEn in BRANCH
//     PCEn      program counter write enable
//     IorD      memory address select (0 = PC, 1 = ALUOut)
//     MemWrite  data memory write strobe
//     IRWrite   instruction register load
//     RegDst    write register select (0 = rt, 1 = rd)
//     MemtoReg  register write data (0 = ALUOut, 1 = memory data register)
//     RegWrite  register file write enable
//     ALUSrcA   ALU A select (0 = PC, 1 = register A)
//     ALUSrcB   ALU B select (00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2)
//     ALUOp     ALU control (00 = add, 01 = subtract, 10 = decode funct)
//     PCSrc     next PC select (00 = ALU result, 01 = ALUOut, 10 = jump target)
//     State     current state code, for debug
//
//   state   | meaning
//   FETCH   | read instruction at PC, PC <= PC + 4
//   DECODE  | read registers, compute branch target
//   MEMADR  | compute lw/sw address
//   MEMRD   | read data memory
//   MEMWB   | write loaded word to rt
//   MEMWR   | write data memory
//   EXECUTE | R-type ALU operation
//   ALUWB   | write ALU result to rd
//   BRANCH  | compare for beq, load PC when equal
//   ADDIEX  | add immediate
//   ADDIWB  | write addi result to rt
//   JUMP    | load jump target into PC

module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   pcen_raw, irwrite_raw;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Op is re-sampled here rather than remembered from DECODE.
            S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        pcen_raw    = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        irwrite_raw = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSrc       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB     = 2'b01;
                irwrite_raw = 1'b1;
                pcen_raw    = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSrc    = 2'b01;
                pcen_raw = Zero;   // combinational: PC loads only when equal
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc    = 2'b10;
                pcen_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Held in FETCH by reset, but the PC and IR must not load while held.
    assign PCEn    = pcen_raw & ~rst;
    assign IRWrite = irwrite_raw & ~rst;
    assign State   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic       Zero;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .State(State)
    );

    always #5 clk = ~clk;

    // {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
    logic [13:0] outs;
    assign outs = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                   ALUSrcA, ALUSrcB, ALUOp, PCSrc};

    function automatic logic [13:0] exp_out(input int s, input logic z, input logic r);
        logic pcen, iord, mw, irw, rd, m2r, rw, sa;
        logic [1:0] sb, ao, ps;
        pcen = 0; iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            0:  begin sb = 2'b01; irw = 1; pcen = 1; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcen = z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pcen = 1; end
            default: ;
        endcase
        if (r) begin pcen = 0; irw = 0; end
        return {pcen, iord, mw, irw, rd, m2r, rw, sa, sb, ao, ps};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input int s, input logic r);
        check({name, " State"}, {28'd0, State}, s);
        check({name, " outputs"}, {18'd0, outs}, {18'd0, exp_out(s, Zero, r)});
    endtask

    typedef struct {
        string           name;
        logic [5:0]      op;
        logic            zero;
        int              n;
        logic [5:0][3:0] seq;   // seq[k] = State after k edges from FETCH
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Sequences written last-to-first because seq is a packed array.
        vecs[0] = '{"lw",      6'b100011, 1'b0, 5, {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        vecs[1] = '{"rtype",   6'b000000, 1'b0, 4, {4'd0, 4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        vecs[2] = '{"beq_z1",  6'b000100, 1'b1, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        vecs[3] = '{"beq_z0",  6'b000100, 1'b0, 3, {4'd0, 4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        vecs[4] = '{"sw",      6'b101011, 1'b0, 4, {4'd0, 4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        vecs[5] = '{"j",       6'b000010, 1'b1, 3, {4'd0, 4'd0, 4'd0, 4'd11, 4'd1, 4'd0}};
        vecs[6] = '{"addi",    6'b001000, 1'b0, 4, {4'd0, 4'd0, 4'd10, 4'd9, 4'd1, 4'd0}};
        vecs[7] = '{"illegal", 6'b111111, 1'b1, 2, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
        vecs[8] = '{"jal_uns", 6'b000011, 1'b0, 2, {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

        rst = 1'b1; Op = 6'b000000; Zero = 1'b0;
        @(negedge clk);
        check_state("reset_hold", 0, 1'b1);
        @(negedge clk);
        check_state("reset_hold2", 0, 1'b1);
        rst = 1'b0;
        #1 check_state("reset_release", 0, 1'b0);

        foreach (vecs[i]) begin
            Op   = vecs[i].op;
            Zero = vecs[i].zero;
            for (int k = 0; k <= vecs[i].n; k++) begin
                if (k > 0) @(negedge clk);
                check_state($sformatf("%s step%0d", vecs[i].name, k), int'(vecs[i].seq[k]), 1'b0);
            end
        end

        // Op changes between DECODE and MEMADR: the MEMADR exit uses the new Op.
        Op = 6'b101011;
        @(negedge clk); check_state("resample decode", 1, 1'b0);
        @(negedge clk); check_state("resample memadr", 2, 1'b0);
        Op = 6'b100011;
        @(negedge clk); check_state("resample memrd", 3, 1'b0);
        @(negedge clk); check_state("resample memwb", 4, 1'b0);
        @(negedge clk); check_state("resample fetch", 0, 1'b0);

        // Zero toggling inside BRANCH moves PCEn without a clock edge.
        Op = 6'b000100; Zero = 1'b0;
        @(negedge clk); @(negedge clk);
        check_state("branch z0", 8, 1'b0);
        Zero = 1'b1;
        #1 check("branch pcen follows zero", {31'd0, PCEn}, 32'd1);
        Zero = 1'b0;
        #1 check("branch pcen drops", {31'd0, PCEn}, 32'd0);
        @(negedge clk); check_state("branch back", 0, 1'b0);

        // Asynchronous reset while in MEMRD.
        Op = 6'b100011;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check_state("async pre", 3, 1'b0);
        #2 rst = 1'b1;
        #1 check_state("async immediate", 0, 1'b1);
        @(negedge clk); check_state("async held", 0, 1'b1);
        rst = 1'b0;
        #1 check_state("async release", 0, 1'b0);
        @(negedge clk); check_state("async first edge", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed.
REQ-002 clk  input  1  single system clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode field, bits [31:26] from the instruction register.
REQ-005 Zero  input  1  ALU zero flag.
REQ-006 PCEn  output  1  program counter write enable.
REQ-007 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 MemWrite  output  1  data memory write strobe.
REQ-009 IRWrite  output  1  instruction register load.
REQ-010 RegDst  output  1  write register select: 0 = rt, 1 = rd.
REQ-011 MemtoReg  output  1  register write data: 0 = ALUOut, 1 = memory data register.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 ALUSrcA  output  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 ALUSrcB  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-015 ALUOp  output  2  to the ALU control decoder: 00 = add, 01 = subtract, 10 = decode funct field.
REQ-016 PCSrc  output  2  next PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-017 State  output  4  current state code, for debug and verification.

Function
REQ-018 The block SHALL be a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-019 Codes 12-15 SHALL transition to FETCH on the next edge and drive all outputs to their inactive (zero) values.
REQ-020 Transitions: FETCH->DECODE on every edge.
REQ-021 DECODE SHALL branch on Op: lw(100011) or sw(101011)->MEMADR; R-type(000000)->EXECUTE; beq(000100)->BRANCH; addi(001000)->ADDIEX; j(000010)->JUMP; any other Op->FETCH.
REQ-022 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw, using Op as sampled in MEMADR.
REQ-023 Remaining transitions: MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP->FETCH.
REQ-024 Every output not listed for a state SHALL be 0 in that state.
REQ-025 FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCEn=1.
REQ-026 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-027 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-028 Memory and writeback states: MEMRD IorD=1; MEMWB RegDst=0, MemtoReg=1, RegWrite=1; MEMWR IorD=1, MemWrite=1.
REQ-029 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-030 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
REQ-031 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero (combinational from Zero; the only non-Moore path). JUMP: PCSrc=10, PCEn=1.
REQ-032 Instruction latency from FETCH entry to the return to FETCH SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; unsupported Op 2 cycles.

Reset
REQ-033 Asserting rst SHALL immediately force State=FETCH, independent of clk, including mid-instruction.
REQ-034 While rst is high, all outputs SHALL hold their FETCH values, except that PCEn and IRWrite SHALL be forced to 0.
REQ-035 The first rising edge after rst deasserts SHALL move FETCH to DECODE.

Verification
REQ-036 lw: with Op=100011 after reset release, State SHALL follow 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-037 R-type then beq: with Op=000000, State SHALL follow 0,1,6,7,0 with ALUOp=10 in state 6. Next, with Op=000100 and Zero=1, State SHALL follow 0,1,8,0 with ALUOp=01 and PCEn=1 in state 8; with Zero=0, PCEn SHALL be 0 in state 8.
REQ-038 sw and j: Op=101011 SHALL give 0,1,2,5,0 with MemWrite=1 only in state 5. Op=000010 SHALL give 0,1,11,0 with PCSrc=10 and PCEn=1 in state 11.
REQ-039 Illegal opcode: Op=111111 SHALL give 0,1,0, with no RegWrite or MemWrite pulse.
REQ-040 Asynchronous reset: rst asserted between edges while in MEMRD SHALL make State read 0 before the next edge, with IRWrite=0 and PCEn=0 until release.
